// File: rtl/bcd_timer_ctrl.sv
// Run/pause/stop sequencer for a cascade of NDIG BCD digits with prescaled count steps.
// Optional BCD_TIMER_AUTORELOAD_EN: reload the last loaded value after terminal instead of stopping.
module bcd_timer_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1000,
    parameter int PW       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              dir,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   dig_en,
    output logic              step,
    output logic              running,
    output logic              done,
    output logic              term
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);

    state_t            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              dir_q, dir_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic              term_q, term_d;

    logic [4*NDIG-1:0] load_sat, stepped, applied;
    logic [NDIG-1:0]   cascade;
    logic [3:0]        lim;
    logic              step_fire, hit;

`ifdef BCD_TIMER_AUTORELOAD_EN
    logic [4*NDIG-1:0] reload_q, reload_d;
    logic              at_term_q, at_term_d;
`endif

    // lim is both the carry/borrow digit and the terminal digit for the active direction.
    assign lim       = dir_q ? 4'd0 : 4'd9;
    assign step_fire = (state_q == S_RUN) && !clear && !load && !stop && (pre_q == PRE_MAX);

    // NOTE: every variable an always_comb writes gets a default first, so no path can infer a latch.
    always_comb begin
        load_sat   = '0;
        stepped    = digits_q;
        cascade    = '0;
        cascade[0] = 1'b1;
        for (int k = 1; k < NDIG; k++) begin
            cascade[k] = cascade[k-1] & (digits_q[4*(k-1) +: 4] == lim);
        end
        for (int k = 0; k < NDIG; k++) begin
            load_sat[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
            if (cascade[k]) begin
                if (dir_q) begin
                    stepped[4*k +: 4] = (digits_q[4*k +: 4] == 4'd0) ? 4'd9 : digits_q[4*k +: 4] - 4'd1;
                end else begin
                    stepped[4*k +: 4] = (digits_q[4*k +: 4] == 4'd9) ? 4'd0 : digits_q[4*k +: 4] + 4'd1;
                end
            end
        end
`ifdef BCD_TIMER_AUTORELOAD_EN
        applied = at_term_q ? reload_q : stepped;
`else
        applied = stepped;
`endif
        hit = (applied == {NDIG{lim}});
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        dir_d    = dir_q;
        digits_d = digits_q;
        term_d   = 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
        reload_d  = reload_q;
        at_term_d = at_term_q;
`endif
        if (clear) begin
            digits_d = '0;
            state_d  = S_IDLE;
            pre_d    = '0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            at_term_d = 1'b0;
`endif
        end else if (load) begin
            digits_d = load_sat;
            state_d  = S_IDLE;
            pre_d    = '0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_d  = load_sat;
            at_term_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_PAUSE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        dir_d   = dir;
                        // A paused run resumes mid-period; a fresh run starts a full period.
                        if (state_q == S_IDLE) pre_d = '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (step_fire) begin
                        pre_d    = '0;
                        digits_d = applied;
                        term_d   = hit;
`ifdef BCD_TIMER_AUTORELOAD_EN
                        at_term_d = hit;
`else
                        if (hit) state_d = S_DONE;
`endif
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            dir_q    <= 1'b0;
            digits_q <= '0;
            term_q   <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_q  <= '0;
            at_term_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            dir_q    <= dir_d;
            digits_q <= digits_d;
            term_q   <= term_d;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_q  <= reload_d;
            at_term_q <= at_term_d;
`endif
        end
    end

    assign digits  = digits_q;
    assign dig_en  = step_fire ? cascade : '0;
    assign step    = step_fire;
    assign running = (state_q == S_RUN);
    assign term    = term_q;
`ifdef BCD_TIMER_AUTORELOAD_EN
    assign done    = 1'b0;
`else
    assign done    = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Table-driven bench for bcd_timer_ctrl (NDIG=2, PRESCALE=3) plus a PRESCALE=1 hand sequence.
module tb_bcd_timer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stop, clear, load, dir;
    logic [7:0] load_val, digits;
    logic [1:0] dig_en;
    logic       step, running, done, term;

    logic       p_rst, p_start, p_stop, p_clear, p_load, p_dir;
    logic [7:0] p_load_val, p_digits;
    logic [1:0] p_dig_en;
    logic       p_step, p_running, p_done, p_term;

    bcd_timer_ctrl #(.NDIG(2), .PRESCALE(3), .PW(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_val(load_val), .dir(dir), .digits(digits), .dig_en(dig_en), .step(step),
        .running(running), .done(done), .term(term)
    );

    bcd_timer_ctrl #(.NDIG(2), .PRESCALE(1), .PW(1)) dut_p1 (
        .clk(clk), .rst(p_rst), .start(p_start), .stop(p_stop), .clear(p_clear), .load(p_load),
        .load_val(p_load_val), .dir(p_dir), .digits(p_digits), .dig_en(p_dig_en), .step(p_step),
        .running(p_running), .done(p_done), .term(p_term)
    );

    typedef enum {C_NONE, C_RST, C_UP, C_DN, C_STOP, C_CLEAR, C_LOAD, C_LOAD_CLEAR} cmd_e;

    typedef struct {
        cmd_e       cmd;
        logic [7:0] lv;
        logic [7:0] e_digits;
        logic [1:0] e_en;
        logic       e_step;
        logic       e_run;
        logic       e_done;
        logic       e_term;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_idx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic void row(input cmd_e c, input logic [7:0] lv, input logic [7:0] d,
                                input logic [1:0] en, input logic st, input logic run,
                                input logic dn, input logic tm);
        vec_t v;
        v.cmd = c; v.lv = lv; v.e_digits = d; v.e_en = en;
        v.e_step = st; v.e_run = run; v.e_done = dn; v.e_term = tm;
        vecs.push_back(v);
    endfunction

    // Three rows per count step: prescaler 0, 1, then 2 with the step firing.
    function automatic void steps_from(input logic [7:0] d, input logic [1:0] en);
        row(C_NONE, 8'h00, d, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        row(C_NONE, 8'h00, d, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        row(C_NONE, 8'h00, d, en,    1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic void build_table();
        // Reset, then count up 00..10 with a two-digit carry on 09 -> 10.
        row(C_RST, 8'h00, 8'h00, 2'b00, 0, 0, 0, 0);
        row(C_UP,  8'h00, 8'h00, 2'b00, 0, 0, 0, 0);
        for (int s = 0; s < 10; s++) steps_from(bcd(s), (s == 9) ? 2'b11 : 2'b01);
        row(C_NONE, 8'h00, 8'h10, 2'b00, 0, 1, 0, 0);
        // Loads saturate nibbles > 9; clear beats load; start at 99 wraps without terminal.
        row(C_LOAD,       8'hA3, 8'h10, 2'b00, 0, 1, 0, 0);
        row(C_LOAD,       8'hF7, 8'h93, 2'b00, 0, 0, 0, 0);
        row(C_LOAD_CLEAR, 8'hAF, 8'h97, 2'b00, 0, 0, 0, 0);
        row(C_LOAD,       8'hAF, 8'h00, 2'b00, 0, 0, 0, 0);
        row(C_UP,         8'h00, 8'h99, 2'b00, 0, 0, 0, 0);
        steps_from(8'h99, 2'b11);
        row(C_NONE,  8'h00, 8'h00, 2'b00, 0, 1, 0, 0);
        row(C_CLEAR, 8'h00, 8'h00, 2'b00, 0, 1, 0, 0);
        row(C_NONE,  8'h00, 8'h00, 2'b00, 0, 0, 0, 0);
`ifdef BCD_TIMER_AUTORELOAD_EN
        // Up from 97: 98, 99 with term, then reload to 97 and keep running.
        row(C_LOAD, 8'h97, 8'h00, 2'b00, 0, 0, 0, 0);
        row(C_UP,   8'h00, 8'h97, 2'b00, 0, 0, 0, 0);
        steps_from(8'h97, 2'b01);
        steps_from(8'h98, 2'b01);
        row(C_NONE, 8'h00, 8'h99, 2'b00, 0, 1, 0, 1);
        row(C_NONE, 8'h00, 8'h99, 2'b00, 0, 1, 0, 0);
        row(C_NONE, 8'h00, 8'h99, 2'b11, 1, 1, 0, 0);
        row(C_NONE, 8'h00, 8'h97, 2'b00, 0, 1, 0, 0);
        row(C_NONE, 8'h00, 8'h97, 2'b00, 0, 1, 0, 0);
        row(C_NONE, 8'h00, 8'h97, 2'b01, 1, 1, 0, 0);
        row(C_NONE, 8'h00, 8'h98, 2'b00, 0, 1, 0, 0);
`else
        // Down from 02 to terminal 00, DONE ignores start.
        row(C_LOAD, 8'h02, 8'h00, 2'b00, 0, 0, 0, 0);
        row(C_DN,   8'h00, 8'h02, 2'b00, 0, 0, 0, 0);
        steps_from(8'h02, 2'b01);
        steps_from(8'h01, 2'b01);
        row(C_UP,   8'h00, 8'h00, 2'b00, 0, 0, 1, 1);
        row(C_UP,   8'h00, 8'h00, 2'b00, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) row(C_NONE, 8'h00, 8'h00, 2'b00, 0, 0, 1, 0);
        // 95 up, pause at 97 with prescaler 1, resume, then 98 and terminal 99.
        row(C_LOAD, 8'h95, 8'h00, 2'b00, 0, 0, 1, 0);
        row(C_UP,   8'h00, 8'h95, 2'b00, 0, 0, 0, 0);
        steps_from(8'h95, 2'b01);
        steps_from(8'h96, 2'b01);
        row(C_NONE, 8'h00, 8'h97, 2'b00, 0, 1, 0, 0);
        row(C_STOP, 8'h00, 8'h97, 2'b00, 0, 1, 0, 0);
        row(C_NONE, 8'h00, 8'h97, 2'b00, 0, 0, 0, 0);
        row(C_NONE, 8'h00, 8'h97, 2'b00, 0, 0, 0, 0);
        row(C_UP,   8'h00, 8'h97, 2'b00, 0, 0, 0, 0);
        row(C_NONE, 8'h00, 8'h97, 2'b00, 0, 1, 0, 0);
        row(C_NONE, 8'h00, 8'h97, 2'b01, 1, 1, 0, 0);
        steps_from(8'h98, 2'b01);
        row(C_NONE, 8'h00, 8'h99, 2'b00, 0, 0, 1, 1);
        row(C_NONE, 8'h00, 8'h99, 2'b00, 0, 0, 1, 0);
`endif
    endfunction

    task automatic apply(input vec_t v);
        rst      = (v.cmd == C_RST);
        start    = (v.cmd == C_UP) || (v.cmd == C_DN);
        dir      = (v.cmd == C_DN);
        stop     = (v.cmd == C_STOP);
        clear    = (v.cmd == C_CLEAR) || (v.cmd == C_LOAD_CLEAR);
        load     = (v.cmd == C_LOAD) || (v.cmd == C_LOAD_CLEAR);
        load_val = v.lv;
    endtask

    // Scoreboard: expected outputs were queued when the row was driven, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            vec_t e;
            e = sb.pop_front();
            check($sformatf("row%0d digits",  mon_idx), digits,  e.e_digits);
            check($sformatf("row%0d dig_en",  mon_idx), dig_en,  e.e_en);
            check($sformatf("row%0d step",    mon_idx), step,    e.e_step);
            check($sformatf("row%0d running", mon_idx), running, e.e_run);
            check($sformatf("row%0d done",    mon_idx), done,    e.e_done);
            check($sformatf("row%0d term",    mon_idx), term,    e.e_term);
            mon_idx++;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; dir = 1'b0; load_val = '0;
        p_rst = 1'b1; p_start = 1'b0; p_stop = 1'b0; p_clear = 1'b0; p_load = 1'b0; p_dir = 1'b0;
        p_load_val = '0;
        build_table();

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            apply(vecs[i]);
            sb.push_back(vecs[i]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        check("rows compared", mon_idx, vecs.size());

        // PRESCALE=1: step every RUN cycle; stop coinciding with a step suppresses it.
        @(posedge clk); #1 p_rst = 1'b0; p_start = 1'b1;
        @(negedge clk);
        check("p1 reset digits",  p_digits,  8'h00);
        check("p1 reset running", p_running, 1'b0);
        check("p1 reset step",    p_step,    1'b0);
        @(posedge clk); #1 p_start = 1'b0;
        @(negedge clk);
        check("p1 first step",    p_step,    1'b1);
        check("p1 first dig_en",  p_dig_en,  2'b01);
        check("p1 running",       p_running, 1'b1);
        @(posedge clk); #1 p_stop = 1'b1;
        @(negedge clk);
        check("p1 stop+step step",   p_step,   1'b0);
        check("p1 stop+step dig_en", p_dig_en, 2'b00);
        check("p1 digits before stop", p_digits, 8'h01);
        @(posedge clk); #1 p_stop = 1'b0;
        @(negedge clk);
        check("p1 paused digits",  p_digits,  8'h01);
        check("p1 paused running", p_running, 1'b0);
        p_start = 1'b1;
        @(posedge clk); #1 p_start = 1'b0;
        @(negedge clk);
        check("p1 resumed step", p_step, 1'b1);
        @(posedge clk); #1 p_rst = 1'b1;
        @(negedge clk);
        check("p1 digits before rst", p_digits, 8'h02);
        @(posedge clk); #1 p_rst = 1'b0;
        @(negedge clk);
        check("p1 rst digits",  p_digits,  8'h00);
        check("p1 rst dig_en",  p_dig_en,  2'b00);
        check("p1 rst step",    p_step,    1'b0);
        check("p1 rst running", p_running, 1'b0);
        check("p1 rst done",    p_done,    1'b0);
        check("p1 rst term",    p_term,    1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
